// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter driving the select of a shared mux41.
// Optional burst limit is enabled by defining RR_ARB4_BURST_LIMIT_EN.

module mux41 (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic [1:0] sel,
  output logic       f
);
  always_comb begin
    f = a;
    case (sel)
      2'd0: f = a;
      2'd1: f = b;
      2'd2: f = c;
      2'd3: f = d;
      default: f = a;
    endcase
  end
endmodule

module rr_arb4 #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy
);
  typedef enum logic {S_IDLE, S_OWNED} state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic [1:0] r_owner, w_owner_nxt;
  logic [1:0] r_sel, w_sel_nxt;
  logic [3:0] r_grant, w_grant_nxt;
  logic       r_busy;
  logic       w_win_vld;
  logic [1:0] w_win_idx;
  logic       w_take;

`ifdef RR_ARB4_BURST_LIMIT_EN
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       w_other;
  assign w_other = |(req & ~(4'b0001 << r_owner));
`else
  localparam int unused_max_burst = MAX_BURST;
`endif

  // Scan from r_ptr downward in distance so the nearest set bit is assigned last.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[r_ptr + 2'(k)]) begin
        w_win_vld = 1'b1;
        w_win_idx = r_ptr + 2'(k);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_sel_nxt   = r_sel;
    w_grant_nxt = r_grant;
    w_take      = 1'b0;
`ifdef RR_ARB4_BURST_LIMIT_EN
    w_cnt_nxt   = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        w_grant_nxt = '0;
        if (w_win_vld) w_take = 1'b1;
      end
      S_OWNED: begin
        // Owner's own bit is low here, so any winner is a different requester.
        if (!req[r_owner]) begin
          if (w_win_vld) w_take = 1'b1;
          else begin
            w_grant_nxt = '0;
            w_state_nxt = S_IDLE;
          end
        end
`ifdef RR_ARB4_BURST_LIMIT_EN
        // r_ptr is already past the owner, so the scan reaches it last.
        else if (r_cnt >= 8'(MAX_BURST) && w_other) w_take = 1'b1;
        else if (r_cnt < 8'(MAX_BURST)) w_cnt_nxt = r_cnt + 8'd1;
`endif
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_take) begin
      w_state_nxt = S_OWNED;
      w_grant_nxt = 4'b0001 << w_win_idx;
      w_sel_nxt   = w_win_idx;
      w_owner_nxt = w_win_idx;
      w_ptr_nxt   = w_win_idx + 2'd1;
`ifdef RR_ARB4_BURST_LIMIT_EN
      w_cnt_nxt   = 8'd1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_sel   <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_sel   <= w_sel_nxt;
      r_grant <= w_grant_nxt;
      r_busy  <= |w_grant_nxt;
    end
  end

`ifdef RR_ARB4_BURST_LIMIT_EN
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= w_cnt_nxt;
  end
`endif

  assign grant = r_grant;
  assign sel   = r_sel;
  assign busy  = r_busy;
endmodule

// File: tb/tb_rr_arb4.sv
// Self-checking bench for rr_arb4: constant vector table, hand sequences for
// burst and mux integration, then random traffic against a behavioural model.

module tb_rr_arb4;
  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       ma, mb, mc, md, mf;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: owner index or -1 when idle
  int m_owner, m_ptr, m_cnt, m_sel;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
  } vec_t;
  vec_t tv[21];

  rr_arb4 #(.MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .sel(sel), .busy(busy)
  );
  mux41 u_mux (.a(ma), .b(mb), .c(mc), .d(md), .sel(sel), .f(mf));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int m_pick(input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_ptr + k) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic m_take(input int w);
    m_owner = w;
    m_sel   = w;
    m_ptr   = (w + 1) % 4;
    m_cnt   = 1;
  endtask

  task automatic m_step(input logic r_rst, input logic [3:0] r);
    int w;
    if (r_rst) begin
      m_owner = -1; m_ptr = 0; m_sel = 0; m_cnt = 0;
    end else if (m_owner < 0 || !r[m_owner]) begin
      w = m_pick(r);
      if (w >= 0) m_take(w);
      else m_owner = -1;
    end else begin
`ifdef RR_ARB4_BURST_LIMIT_EN
      if (m_cnt >= MB && (r & ~(4'b0001 << m_owner)) != 4'b0) m_take(m_pick(r));
      else if (m_cnt < MB) m_cnt++;
`endif
    end
  endtask

  task automatic tick_model();
    logic [3:0] eg;
    m_step(rst, req);
    cycle();
    eg = (m_owner < 0) ? 4'b0 : (4'b0001 << m_owner);
    chk("rand_grant", grant, eg);
    chk("rand_sel", {2'b0, sel}, 4'(m_sel));
    chk("rand_busy", {3'b0, busy}, {3'b0, m_owner >= 0});
  endtask

  initial begin
    rst = 1'b1; req = 4'b0;
    ma = 1'b0; mb = 1'b1; mc = 1'b0; md = 1'b1;

    // reset, single request, round robin 0..3..0, reset mid-grant
    tv[0]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};
    tv[1]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};
    tv[2]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};
    tv[3]  = '{1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0};
    tv[4]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
    tv[5]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0};
    tv[6]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0};
    tv[7]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};
    tv[8]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};
    tv[9]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};
    tv[10] = '{1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1};
    tv[11] = '{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1};
    tv[12] = '{1'b0, 4'b1101, 4'b0100, 2'd2, 1'b1};
    tv[13] = '{1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1};
    tv[14] = '{1'b0, 4'b1011, 4'b1000, 2'd3, 1'b1};
    tv[15] = '{1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1};
    tv[16] = '{1'b0, 4'b0111, 4'b0001, 2'd0, 1'b1};
    tv[17] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};
    tv[18] = '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1};
    tv[19] = '{1'b1, 4'b1001, 4'b0000, 2'd0, 1'b0};
    tv[20] = '{1'b0, 4'b1001, 4'b0001, 2'd0, 1'b1};

    for (int i = 0; i < 21; i++) begin
      rst = tv[i].rst;
      req = tv[i].req;
      cycle();
      chk($sformatf("vec%0d_grant", i), grant, tv[i].g);
      chk($sformatf("vec%0d_sel", i), {2'b0, sel}, {2'b0, tv[i].s});
      chk($sformatf("vec%0d_busy", i), {3'b0, busy}, {3'b0, tv[i].b});
    end

    // burst: two requesters held constant
    rst = 1'b1; req = 4'b0; cycle();
    rst = 1'b0; req = 4'b0011;
    for (int k = 1; k <= 16; k++) begin
      logic [3:0] eg;
      cycle();
`ifdef RR_ARB4_BURST_LIMIT_EN
      eg = (((k - 1) / MB) % 2 == 1) ? 4'b0010 : 4'b0001;
`else
      eg = 4'b0001;
`endif
      chk($sformatf("burst%0d", k), grant, eg);
    end

    // mux integration: b=1, a=0
    rst = 1'b1; req = 4'b0; cycle();
    rst = 1'b0; req = 4'b0010; cycle();
    chk("mux_grant_b", grant, 4'b0010);
    chk("mux_f_b", {3'b0, mf}, 4'b0001);
    req = 4'b0000; cycle();
    chk("mux_rel_grant", grant, 4'b0000);
    chk("mux_rel_sel", {2'b0, sel}, 4'd1);
    chk("mux_rel_f", {3'b0, mf}, 4'b0001);
    req = 4'b0001; cycle();
    chk("mux_grant_a", grant, 4'b0001);
    chk("mux_f_a", {3'b0, mf}, 4'b0000);

    // random traffic vs. model
    rst = 1'b1; req = 4'b0;
    tick_model();
    rst = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
      tick_model();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
